hex_display_scanner: RTL

Time-multiplexed scanner for a common-anode multi-digit hex display. Holds a DIGITS-nibble display value and selects one digit per refresh tick. Drives that digit's nibble into the downstream seven-segment decoder, plus an active-low digit-enable bus. New values arrive over a valid/ready handshake and take effect only at frame boundaries, so a frame never shows a mix of old and new digits.

---
 rtl/hex_display_scanner.sv | 84 ++++++++
 1 files changed

// File: rtl/hex_display_scanner.sv
// Time-multiplexed scanner for a common-anode hex display with frame-aligned value updates.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module hex_display_scanner #(
    parameter int DIGITS  = 4,
    parameter int CLK_DIV = 50000,
    parameter int CNT_W   = $clog2(CLK_DIV + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  value_valid,
    output logic                  value_ready,
    output logic [3:0]            nibble,
    output logic [DIGITS-1:0]     an,
    output logic                  blank,
    output logic                  frame_start
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [CNT_W-1:0] PRE_MAX = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]    prescaler;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] display;
    logic [4*DIGITS-1:0] pending;
    logic                pending_full;
    logic                tick;
    logic                boundary;

    assign tick     = (prescaler == PRE_MAX);
    assign boundary = tick && (idx == IDX_MAX);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler    <= '0;
            idx          <= '0;
            display      <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
            frame_start  <= 1'b0;
        end else begin
            prescaler   <= tick ? '0 : prescaler + 1'b1;
            frame_start <= boundary;
            if (tick) begin
                idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
            end
            // Transfer and accept are exclusive: accept needs an empty slot, transfer a full one.
            if (boundary && pending_full) begin
                display      <= pending;
                pending_full <= 1'b0;
            end else if (value_valid && !pending_full) begin
                pending      <= value;
                pending_full <= 1'b1;
            end
        end
    end

    assign value_ready = !pending_full;

    always_comb begin
        nibble = display[4*int'(idx) +: 4];
        an     = ~(DIGITS'(1) << idx);
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [IDX_W-1:0] msd;

    // Digit 0 is never blanked, so an all-zero display still shows a single "0".
    always_comb begin
        msd = '0;
        for (int i = 1; i < DIGITS; i++) begin
            if (display[4*i +: 4] != 4'h0) begin
                msd = IDX_W'(i);
            end
        end
        blank = (idx > msd);
    end
`else
    assign blank = 1'b0;
`endif

endmodule
